// File: rtl/bram_s16_bit_reader_pkg.sv
// Shared definitions for the bit-serial block-RAM reader: FSM states and word/counter widths.
package bram_s16_bit_reader_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/bram_s16_bit_reader_word_shifter.sv
// 16-bit load/shift-right register with a bit counter; 'last' flags the 16th bit of a word.
module bram_word_shifter
    import bram_s16_bit_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0]    word;
    logic [BIT_CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            word    <= din;
            bit_cnt <= '0;
        end else if (shift) begin
            word    <= {1'b0, word[WORD_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign bit_out = word[0];
    assign last    = &bit_cnt;

endmodule

// File: rtl/bram_s16_bit_reader.sv
// Bit-serial drain of a 16-bit BRAM read port, LSB first, gapless across words.
// Optional BRAM_BIT_READER_LOOP_EN: restart at the captured address after every pass until ABORT.
module bram_s16_bit_reader
    import bram_s16_bit_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   NUM_WORDS,
    input  logic              ABORT,
    output logic              RAM_EN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [DATA_W-1:0] RAM_DO,
    output logic              BIT_OUT,
    output logic              BIT_VALID,
    input  logic              BIT_READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    if (DATA_W != WORD_W) begin : g_bad_width
        $error("bram_s16_bit_reader: DATA_W must be 16");
    end

    state_t            state;
    logic [ADDR_W-1:0] start_addr_q;
    logic [CNT_W-1:0]  num_words_q;
    logic [CNT_W-1:0]  words_left;
    logic              beat;
    logic              last_bit;
    logic              shift_load;
    logic              shift_en;

    assign beat       = BIT_VALID & BIT_READY;
    // Reload from the prefetched RAM_DO on the 16th beat keeps the stream gapless.
    assign shift_load = (state == ST_LOAD) ||
                        ((state == ST_STREAM) && beat && last_bit && (words_left != '0));
    assign shift_en   = (state == ST_STREAM) && beat;
    assign BUSY       = (state != ST_IDLE);

    bram_word_shifter u_shifter (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (shift_load),
        .shift   (shift_en),
        .din     (RAM_DO),
        .bit_out (BIT_OUT),
        .last    (last_bit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            RAM_EN       <= 1'b0;
            RAM_ADDR     <= '0;
            BIT_VALID    <= 1'b0;
            DONE         <= 1'b0;
            start_addr_q <= '0;
            num_words_q  <= '0;
            words_left   <= '0;
        end else begin
            RAM_EN <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START && !ABORT) begin
                        if (NUM_WORDS == '0) begin
                            DONE <= 1'b1;
                        end else begin
                            state        <= ST_FETCH;
                            RAM_EN       <= 1'b1;
                            RAM_ADDR     <= START_ADDR;
                            start_addr_q <= START_ADDR;
                            num_words_q  <= NUM_WORDS;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state      <= ST_STREAM;
                    BIT_VALID  <= 1'b1;
                    words_left <= num_words_q - CNT_W'(1);
                    if (num_words_q != CNT_W'(1)) begin
                        RAM_EN   <= 1'b1;
                        RAM_ADDR <= start_addr_q + ADDR_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (beat && last_bit) begin
                        if (words_left != '0) begin
                            words_left <= words_left - CNT_W'(1);
                            if (words_left != CNT_W'(1)) begin
                                RAM_EN   <= 1'b1;
                                RAM_ADDR <= RAM_ADDR + ADDR_W'(1);
                            end
                        end else begin
                            BIT_VALID <= 1'b0;
                            DONE      <= 1'b1;
`ifdef BRAM_BIT_READER_LOOP_EN
                            state    <= ST_FETCH;
                            RAM_EN   <= 1'b1;
                            RAM_ADDR <= start_addr_q;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // ABORT overrides whatever the state logic scheduled this cycle.
            if (ABORT && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                BIT_VALID <= 1'b0;
                RAM_EN    <= 1'b0;
                DONE      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_s16_bit_reader.sv
// Directed bench for bram_s16_bit_reader with a preloaded 1-cycle registered-read RAM model.
module tb_bram_s16_bit_reader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [7:0]  START_ADDR;
    logic [8:0]  NUM_WORDS;
    logic        ABORT;
    logic        RAM_EN;
    logic [7:0]  RAM_ADDR;
    logic [15:0] RAM_DO = '0;
    logic        BIT_OUT;
    logic        BIT_VALID;
    logic        BIT_READY;
    logic        BUSY;
    logic        DONE;

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int nb = 0, ram_en_cnt = 0, done_cnt = 0, valid_cnt = 0, hold_err = 0;
    int done_cyc = 0, last_beat_cyc = 0;
    logic       bit_log  [0:1023];
    logic [7:0] addr_log [0:63];
    logic       prev_stall = 1'b0;
    logic       prev_bit   = 1'b0;

    bram_s16_bit_reader #(.ADDR_W(8), .DATA_W(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .START_ADDR (START_ADDR),
        .NUM_WORDS  (NUM_WORDS),
        .ABORT      (ABORT),
        .RAM_EN     (RAM_EN),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_DO     (RAM_DO),
        .BIT_OUT    (BIT_OUT),
        .BIT_VALID  (BIT_VALID),
        .BIT_READY  (BIT_READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RAM_EN) RAM_DO <= mem[RAM_ADDR];
    end

    // Observe on the falling edge: what is seen here is what the next rising edge accepts.
    always @(negedge CLK) begin
        if (BIT_VALID) valid_cnt++;
        if (BIT_VALID && BIT_READY) begin
            bit_log[nb % 1024] = BIT_OUT;
            nb++;
            last_beat_cyc = cyc;
        end
        if (RAM_EN) begin
            addr_log[ram_en_cnt % 64] = RAM_ADDR;
            ram_en_cnt++;
        end
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall && (!BIT_VALID || BIT_OUT !== prev_bit)) hold_err++;
        prev_stall = BIT_VALID && !BIT_READY;
        prev_bit   = BIT_OUT;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] addr, input logic [8:0] n);
        START      = 1'b1;
        START_ADDR = addr;
        NUM_WORDS  = n;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; BIT_READY = 1'b1;
        START_ADDR = '0; NUM_WORDS = '0;
        repeat (2) tick();
        checks++;
        if ({RAM_EN, BIT_VALID, BIT_OUT, BUSY, DONE} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 00000", {RAM_EN, BIT_VALID, BIT_OUT, BUSY, DONE});
        end
        checks++;
        if (RAM_ADDR !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr got %h exp 00", RAM_ADDR);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic run_two_words(input string name, input logic [7:0] addr,
                                 input logic [31:0] exp_bits, input bit random_ready);
        int n0 = nb;
        int d0 = done_cnt;
        int h0 = hold_err;
        logic [31:0] got;
        BIT_READY = 1'b1;
        start_xfer(addr, 9'd2);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            if (random_ready) BIT_READY = 1'($urandom_range(0, 1));
            tick();
        end
        BIT_READY = 1'b1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL %s_done got %0d exp %0d", name, done_cnt - d0, 1);
        end
        checks++;
        if (nb - n0 !== 32) begin
            errors++;
            $display("FAIL %s_beats got %0d exp 32", name, nb - n0);
        end
        for (int i = 0; i < 32; i++) got[i] = bit_log[(n0 + i) % 1024];
        checks++;
        if (got !== exp_bits) begin
            errors++;
            $display("FAIL %s_bits got %h exp %h", name, got, exp_bits);
        end
        checks++;
        if (done_cyc !== last_beat_cyc + 1) begin
            errors++;
            $display("FAIL %s_done_timing got %0d exp %0d", name, done_cyc, last_beat_cyc + 1);
        end
        checks++;
        if (hold_err !== h0) begin
            errors++;
            $display("FAIL %s_hold got %0d exp %0d", name, hold_err - h0, 0);
        end
        checks++;
        if (BUSY !== 1'b0 || BIT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got %b%b exp 00", name, BUSY, BIT_VALID);
        end
    endtask

    task automatic test_basic;
        BIT_READY = 1'b1;
        start_xfer(8'h10, 9'd2);
        checks++;
        if ({RAM_EN, BUSY, BIT_VALID} !== 3'b110 || RAM_ADDR !== 8'h10) begin
            errors++;
            $display("FAIL fetch got en/busy/valid %b addr %h exp 110 addr 10",
                     {RAM_EN, BUSY, BIT_VALID}, RAM_ADDR);
        end
        tick();
        checks++;
        if (BIT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL latency_1 got %b exp 0", BIT_VALID);
        end
        tick();
        checks++;
        if (BIT_VALID !== 1'b1 || BIT_OUT !== 1'b1) begin
            errors++;
            $display("FAIL latency_2 got valid %b bit %b exp 1 1", BIT_VALID, BIT_OUT);
        end
        for (int i = 0; i < 100 && BUSY; i++) tick();
        tick();
        // Second run checks the full stream from a fresh START.
        run_two_words("basic", 8'h10, 32'h0F0F_A5C3, 1'b0);
    endtask

    task automatic test_random_ready;
        run_two_words("random", 8'h10, 32'h0F0F_A5C3, 1'b1);
    endtask

    task automatic test_wrap;
        int e0 = ram_en_cnt;
        run_two_words("wrap", 8'hFF, 32'hABCD_1234, 1'b0);
        checks++;
        if (ram_en_cnt - e0 !== 2) begin
            errors++;
            $display("FAIL wrap_en_pulses got %0d exp 2", ram_en_cnt - e0);
        end
        checks++;
        if (addr_log[e0 % 64] !== 8'hFF || addr_log[(e0 + 1) % 64] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addrs got %h %h exp ff 00", addr_log[e0 % 64], addr_log[(e0 + 1) % 64]);
        end
    endtask

    task automatic test_zero_words;
        int e0 = ram_en_cnt;
        int v0 = valid_cnt;
        int d0 = done_cnt;
        start_xfer(8'h40, 9'd0);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done %b busy %b exp 1 0", DONE, BUSY);
        end
        repeat (4) tick();
        checks++;
        if (ram_en_cnt !== e0 || valid_cnt !== v0 || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL zero_quiet got en %0d valid %0d done %0d exp 0 0 1",
                     ram_en_cnt - e0, valid_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_abort;
        int n0 = nb;
        int d0 = done_cnt;
        logic [19:0] got;
        BIT_READY = 1'b1;
        start_xfer(8'h20, 9'd4);
        for (int i = 0; i < 100 && (nb - n0) < 20; i++) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        checks++;
        if ({BIT_VALID, BUSY, RAM_EN} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle got %b exp 000", {BIT_VALID, BUSY, RAM_EN});
        end
        for (int i = 0; i < 20; i++) got[i] = bit_log[(n0 + i) % 1024];
        checks++;
        if (got !== 20'h2_1111) begin
            errors++;
            $display("FAIL abort_bits got %h exp 21111", got);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0);
        end
        START = 1'b1; ABORT = 1'b1; START_ADDR = 8'h10; NUM_WORDS = 9'd2;
        tick();
        START = 1'b0; ABORT = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || RAM_EN !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_same got busy %b en %b exp 0 0", BUSY, RAM_EN);
        end
        tick();
        run_two_words("restart", 8'h10, 32'h0F0F_A5C3, 1'b0);
    endtask

    task automatic test_reset_mid;
        BIT_READY = 1'b1;
        start_xfer(8'h20, 9'd4);
        repeat (10) tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if ({RAM_EN, BIT_VALID, BIT_OUT, BUSY, DONE} !== 5'b0 || RAM_ADDR !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid got %b addr %h exp 00000 addr 00",
                     {RAM_EN, BIT_VALID, BIT_OUT, BUSY, DONE}, RAM_ADDR);
        end
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_loop;
        int n0 = nb;
        int d0 = done_cnt;
        int t1 = 0;
        logic [31:0] got;
        BIT_READY = 1'b1;
        start_xfer(8'h30, 9'd1);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        t1 = done_cyc;
        for (int i = 0; i < 200 && done_cnt == d0 + 1; i++) tick();
        checks++;
        if (done_cnt !== d0 + 2 || done_cyc - t1 !== 18) begin
            errors++;
            $display("FAIL loop_period got dones %0d gap %0d exp 2 18", done_cnt - d0, done_cyc - t1);
        end
        for (int i = 0; i < 32; i++) got[i] = bit_log[(n0 + i) % 1024];
        checks++;
        if (got !== 32'h0001_0001) begin
            errors++;
            $display("FAIL loop_bits got %h exp 00010001", got);
        end
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        d0 = done_cnt;
        repeat (30) tick();
        checks++;
        if (BUSY !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL loop_abort got busy %b dones %0d exp 0 0", BUSY, done_cnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hA5C3;
        mem[8'h11] = 16'h0F0F;
        mem[8'hFF] = 16'h1234;
        mem[8'h00] = 16'hABCD;
        mem[8'h20] = 16'h1111;
        mem[8'h21] = 16'h2222;
        mem[8'h22] = 16'h3333;
        mem[8'h23] = 16'h4444;
        mem[8'h30] = 16'h0001;

        test_reset();
`ifdef BRAM_BIT_READER_LOOP_EN
        test_loop();
`else
        test_basic();
        test_random_ready();
        test_wrap();
        test_zero_words();
        test_abort();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
